ps2_id_buffer: RTL and testbench



---
 rtl/ps2_id_buffer_pkg.sv | 53 +++++
 rtl/ps2_id_buffer_if.sv | 27 ++
 rtl/ps2_id_buffer_key_edge.sv | 18 +
 rtl/ps2_id_buffer.sv | 102 ++++++++++
 tb/tb_ps2_id_buffer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_id_buffer_pkg.sv
// Shared definitions for the keystroke-to-ID front end: PS/2 set-2 scan codes,
// the ID buffer state enum and a digit decoder.
package parking_pkg;

  localparam int ID_DIGITS_DEFAULT = 7;

  localparam logic [7:0] SC_0    = 8'h45;
  localparam logic [7:0] SC_1    = 8'h16;
  localparam logic [7:0] SC_2    = 8'h1E;
  localparam logic [7:0] SC_3    = 8'h26;
  localparam logic [7:0] SC_4    = 8'h25;
  localparam logic [7:0] SC_5    = 8'h2E;
  localparam logic [7:0] SC_6    = 8'h36;
  localparam logic [7:0] SC_7    = 8'h3D;
  localparam logic [7:0] SC_8    = 8'h3E;
  localparam logic [7:0] SC_9    = 8'h46;
  localparam logic [7:0] SC_ESC  = 8'h76;
  localparam logic [7:0] SC_CTRL = 8'h14;
  localparam logic [7:0] SC_A    = 8'h1C;
  localparam logic [7:0] SC_BKSP = 8'h66;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } id_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } digit_t;

  function automatic digit_t decode_digit(input logic [7:0] code);
    digit_t r;
    r.valid = 1'b1;
    r.value = 4'd0;
    case (code)
      SC_0:    r.value = 4'd0;
      SC_1:    r.value = 4'd1;
      SC_2:    r.value = 4'd2;
      SC_3:    r.value = 4'd3;
      SC_4:    r.value = 4'd4;
      SC_5:    r.value = 4'd5;
      SC_6:    r.value = 4'd6;
      SC_7:    r.value = 4'd7;
      SC_8:    r.value = 4'd8;
      SC_9:    r.value = 4'd9;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_id_buffer_if.sv
// Key-event input and ID/flag output bundle of ps2_id_buffer, plus the buffer
// state for debug. There is no handshake: key_pressed is a one-cycle strobe.
interface ps2_id_buffer_if
  import parking_pkg::*;
#(
  parameter int ID_DIGITS = ID_DIGITS_DEFAULT
);
  logic [7:0]             key1_code;
  logic                   key1_on;
  logic                   key_pressed;
  logic [3:0]             key;
  logic [4*ID_DIGITS-1:0] ID;
  logic                   buffer_full;
  logic                   esc_pressed;
  logic                   ctrla_pressed;
  id_state_e              dbg_state;

  modport master (
    output key1_code, key1_on,
    input  key_pressed, key, ID, buffer_full, esc_pressed, ctrla_pressed, dbg_state
  );

  modport slave (
    input  key1_code, key1_on,
    output key_pressed, key, ID, buffer_full, esc_pressed, ctrla_pressed, dbg_state
  );
endinterface

// File: rtl/ps2_id_buffer_key_edge.sv
// Rising-edge detector on key1_on. on_q deliberately ignores reset so that a
// key held through reset is not seen as a fresh press.
module ps2_key_edge (
  input  logic       clk,
  input  logic       key1_on_i,
  input  logic [7:0] key1_code_i,
  output logic       press_o,
  output logic [7:0] code_o
);
  logic on_q;

  always_ff @(posedge clk) begin
    on_q <= key1_on_i;
  end

  assign press_o = key1_on_i & ~on_q;
  assign code_o  = key1_code_i;
endmodule

// File: rtl/ps2_id_buffer.sv
// Turns PS/2 key presses into a packed BCD ID with full/Esc/Ctrl+A flags.
// Optional feature: define ID_BACKSPACE_EN to make 0x66 delete the last digit.
module ps2_id_buffer
  import parking_pkg::*;
#(
  parameter int ID_DIGITS = ID_DIGITS_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  ps2_id_buffer_if.slave bus
);
  localparam int IDW = 4 * ID_DIGITS;
  localparam int CW  = $clog2(ID_DIGITS + 1);

  logic       press;
  logic [7:0] code;
  digit_t     dig_d;
  logic       known_d;
  logic [CW-1:0] cnt_inc_d;

  id_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [IDW-1:0] id_q;
  logic [3:0]    key_q;
  logic          key_pressed_q, full_q, esc_q, ctrla_q, armed_q;

  ps2_key_edge u_edge (
    .clk         (clk),
    .key1_on_i   (bus.key1_on),
    .key1_code_i (bus.key1_code),
    .press_o     (press),
    .code_o      (code)
  );

  assign dig_d     = decode_digit(code);
  assign cnt_inc_d = cnt_q + CW'(1);

  // Only recognised codes count as a press for the Ctrl arming logic.
`ifdef ID_BACKSPACE_EN
  assign known_d = dig_d.valid | (code == SC_ESC) | (code == SC_CTRL) |
                   (code == SC_A) | (code == SC_BKSP);
`else
  assign known_d = dig_d.valid | (code == SC_ESC) | (code == SC_CTRL) |
                   (code == SC_A);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= EMPTY;
      cnt_q         <= '0;
      id_q          <= '0;
      key_q         <= '0;
      key_pressed_q <= 1'b0;
      full_q        <= 1'b0;
      esc_q         <= 1'b0;
      ctrla_q       <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      key_pressed_q <= 1'b0;
      if (press && known_d) begin
        armed_q <= 1'b0;
        if (armed_q && code == SC_A) begin
          ctrla_q       <= 1'b1;
          key_pressed_q <= 1'b1;
        end else if (dig_d.valid) begin
          if (state_q != FULL) begin
            id_q          <= {id_q[IDW-5:0], dig_d.value};
            key_q         <= dig_d.value;
            cnt_q         <= cnt_inc_d;
            key_pressed_q <= 1'b1;
            if (cnt_inc_d == CW'(ID_DIGITS)) begin
              state_q <= FULL;
              full_q  <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end
        end else if (code == SC_ESC) begin
          esc_q         <= 1'b1;
          key_pressed_q <= 1'b1;
        end else if (code == SC_CTRL) begin
          armed_q <= 1'b1;
`ifdef ID_BACKSPACE_EN
        end else if (code == SC_BKSP && state_q == COLLECT) begin
          id_q          <= id_q >> 4;
          cnt_q         <= cnt_q - CW'(1);
          key_pressed_q <= 1'b1;
          if (cnt_q == CW'(1)) state_q <= EMPTY;
`endif
        end
      end
    end
  end

  assign bus.key_pressed   = key_pressed_q;
  assign bus.key           = key_q;
  assign bus.ID            = id_q;
  assign bus.buffer_full   = full_q;
  assign bus.esc_pressed   = esc_q;
  assign bus.ctrla_pressed = ctrla_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_ps2_id_buffer.sv
// Directed bench for ps2_id_buffer: an ID-level model checked every cycle plus
// literal expectations per scenario. Honours ID_BACKSPACE_EN like the RTL.
module tb_ps2_id_buffer;
  import parking_pkg::*;

  localparam int N = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;

  ps2_id_buffer_if #(.ID_DIGITS(N)) bus ();

  ps2_id_buffer #(.ID_DIGITS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: the typed digits, first typed at index 0.
  logic [3:0] exp_q[$];
  logic [3:0] m_key;
  bit m_pulse, m_esc, m_ctrla, m_armed;
  bit check_en = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int pulse_cnt = 0;

  byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input byte unsigned c);
    for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [4*N-1:0] model_id();
    logic [4*N-1:0] v = '0;
    foreach (exp_q[i]) v = v * 16 + (4*N)'(exp_q[i]);
    return v;
  endfunction

  function automatic int model_state();
    if (exp_q.size() == 0) return int'(EMPTY);
    if (exp_q.size() == N) return int'(FULL);
    return int'(COLLECT);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_key = 4'd0; m_pulse = 0; m_esc = 0; m_ctrla = 0; m_armed = 0;
  endtask

  task automatic model_apply(input byte unsigned c);
    int d;
    bit known, was_armed;
    d = digit_of(c);
    known = (d >= 0) || c == 8'h76 || c == 8'h14 || c == 8'h1C;
`ifdef ID_BACKSPACE_EN
    known = known || c == 8'h66;
`endif
    if (!known) return;
    was_armed = m_armed;
    m_armed = 0;
    if (was_armed && c == 8'h1C) begin
      m_ctrla = 1; m_pulse = 1;
    end else if (d >= 0) begin
      if (exp_q.size() < N) begin
        exp_q.push_back(4'(d)); m_key = 4'(d); m_pulse = 1;
      end
    end else if (c == 8'h76) begin
      m_esc = 1; m_pulse = 1;
    end else if (c == 8'h14) begin
      m_armed = 1;
    end else if (c == 8'h66) begin
      if (exp_q.size() > 0 && exp_q.size() < N) begin
        void'(exp_q.pop_back()); m_pulse = 1;
      end
    end
  endtask

  task automatic press_key(input byte unsigned c);
    @(posedge clk); #2;
    bus.key1_on = 1'b1; bus.key1_code = c;
    @(posedge clk); #1; model_apply(c);
    @(posedge clk); #1; m_pulse = 0;
    #1 bus.key1_on = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1 model_reset();
    #1 reset = 1'b1;
  endtask

  task automatic type_keys(input byte unsigned keys[$]);
    foreach (keys[i]) press_key(keys[i]);
  endtask

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("key_pressed", bus.key_pressed, m_pulse);
      check("key", bus.key, m_key);
      check("ID", bus.ID, model_id());
      check("buffer_full", bus.buffer_full, exp_q.size() == N);
      check("esc_pressed", bus.esc_pressed, m_esc);
      check("ctrla_pressed", bus.ctrla_pressed, m_ctrla);
      check("state", int'(bus.dbg_state), model_state());
      if (bus.key_pressed === 1'b1) pulse_cnt++;
    end
  end

  initial begin
    bus.key1_on = 1'b0;
    bus.key1_code = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    check("rst_ID", bus.ID, 0);
    check("rst_key_pressed", bus.key_pressed, 0);
    check("rst_full", bus.buffer_full, 0);

    // Full ID entry
    pulse_cnt = 0;
    type_keys('{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D});
    check("full_pulses", pulse_cnt, 7);
    check("full_ID", bus.ID, 28'h1234567);
    check("full_flag", bus.buffer_full, 1);
    check("full_key", bus.key, 7);

    // Digit while full is dropped; Esc still pulses and keeps the ID
    press_key(8'h3E);
    check("full_ignore_pulses", pulse_cnt, 7);
    check("full_ignore_ID", bus.ID, 28'h1234567);
    press_key(8'h76);
    check("esc_full_pulses", pulse_cnt, 8);
    check("esc_full_ID", bus.ID, 28'h1234567);

    // Esc and Ctrl+A after a clear
    do_reset();
    pulse_cnt = 0;
    press_key(8'h76);
    check("esc_pulses", pulse_cnt, 1);
    check("esc_flag", bus.esc_pressed, 1);
    check("esc_ID", bus.ID, 0);
    press_key(8'h1C);
    check("bare_a_pulses", pulse_cnt, 1);
    check("bare_a_flag", bus.ctrla_pressed, 0);
    type_keys('{8'h14, 8'h1C});
    check("ctrla_pulses", pulse_cnt, 2);
    check("ctrla_flag", bus.ctrla_pressed, 1);
    type_keys('{8'h14, 8'h2E});
    check("ctrl_digit_pulses", pulse_cnt, 3);
    check("ctrl_digit_ID", bus.ID, 28'h0000005);

    // Key held across a one-cycle reset must not fire
    pulse_cnt = 0;
    @(posedge clk); #2;
    reset = 1'b0; bus.key1_on = 1'b1; bus.key1_code = 8'h16;
    @(posedge clk); #1 model_reset();
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 bus.key1_on = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("held_pulses", pulse_cnt, 0);
    check("held_ID", bus.ID, 0);
    check("held_key", bus.key, 0);

    // Unmapped code is ignored
    do_reset();
    pulse_cnt = 0;
    type_keys('{8'h1E, 8'h26, 8'h29});
    check("unmapped_pulses", pulse_cnt, 2);
    check("unmapped_ID", bus.ID, 28'h0000023);

`ifdef ID_BACKSPACE_EN
    do_reset();
    pulse_cnt = 0;
    type_keys('{8'h25, 8'h2E, 8'h66});
    check("bksp_pulses", pulse_cnt, 3);
    check("bksp_ID", bus.ID, 28'h0000004);
    check("bksp_key", bus.key, 5);
    type_keys('{8'h66, 8'h66});
    check("bksp_empty_pulses", pulse_cnt, 4);
    check("bksp_empty_ID", bus.ID, 0);
    check("bksp_empty_state", int'(bus.dbg_state), int'(EMPTY));
`else
    press_key(8'h66);
    check("bksp_off_pulses", pulse_cnt, 2);
    check("bksp_off_ID", bus.ID, 28'h0000023);
`endif

    repeat (3) @(posedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
